// File: rtl/icache_responder.sv
// icache_responder: IF fetch port, direct-mapped word cache, byte-serial fill.
// Cache arrays are built only when ICACHE_EN is defined; otherwise all miss.
module icache_responder #(
  parameter int INDEX_BITS = 7
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        IF_req_in,
  input  logic [17:0] IF_addr_in,
  output logic        instE_out,
  output logic [31:0] inst_out,
  output logic        MC_req_out,
  output logic [17:0] MC_addr_out,
  input  logic        MC_grant_in,
  input  logic [7:0]  MC_data_in
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 16 - INDEX_BITS;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]  state;
  logic [15:0] word;
  logic [2:0]  iss;
  logic [2:0]  rcv;
  logic        pend;
  logic [31:0] fill;

  logic [15:0] req_word;
  logic        hit;
  logic [31:0] hit_data;
  logic        abort;
  logic        take;
  logic        last;
  logic        complete;
  logic [31:0] fill_word;
  logic        unused_lsb;

  assign req_word   = IF_addr_in[17:2];
  assign unused_lsb = ^IF_addr_in[1:0];

  // Leaving FILL early: IF dropped or moved its request.
  assign abort = (state == FILL) &&
                 (!IF_req_in || (req_word != word));

  // A grant is only meaningful while bytes remain to be issued.
  assign take = MC_grant_in && !iss[2];

  assign last      = pend && (rcv == 3'd3);
  assign complete  = (state == FILL) && !abort && last;
  assign fill_word = {MC_data_in, fill[23:0]};

`ifdef ICACHE_EN
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tags  [LINES];
  logic [31:0]           lines [LINES];
  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0]   rd_tag;

  assign rd_idx   = req_word[INDEX_BITS-1:0];
  assign wr_idx   = word[INDEX_BITS-1:0];
  assign rd_tag   = req_word[15:INDEX_BITS];
  assign hit      = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign hit_data = lines[rd_idx];

  // Valid bits: cleared by reset, set when a fill completes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid <= '0;
    end else if (rdy_in && complete) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are plain storage, written at fill completion.
  always_ff @(posedge clk_in) begin
    if (rdy_in && complete) begin
      tags[wr_idx]  <= word[15:INDEX_BITS];
      lines[wr_idx] <= fill_word;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // Request FSM: hit service, miss issue/receive, completion and abort.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      word        <= '0;
      iss         <= '0;
      rcv         <= '0;
      pend        <= 1'b0;
      fill        <= '0;
      instE_out   <= 1'b0;
      inst_out    <= '0;
      MC_req_out  <= 1'b0;
      MC_addr_out <= '0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (IF_req_in && hit) begin
            instE_out <= 1'b1;
            inst_out  <= hit_data;
          end else if (IF_req_in) begin
            instE_out   <= 1'b0;
            word        <= req_word;
            state       <= FILL;
            iss         <= '0;
            rcv         <= '0;
            pend        <= 1'b0;
            MC_req_out  <= 1'b1;
            MC_addr_out <= {req_word, 2'b00};
          end else begin
            instE_out <= 1'b0;
          end
        end
        FILL: begin
          instE_out <= 1'b0;
          if (abort) begin
            state      <= IDLE;
            MC_req_out <= 1'b0;
            pend       <= 1'b0;
          end else begin
            pend <= take;
            if (take) begin
              iss         <= iss + 3'd1;
              MC_addr_out <= {word, 2'b00} + 18'(iss) + 18'd1;
              if (iss == 3'd3) begin
                MC_req_out <= 1'b0;
              end
            end
            if (pend) begin
              fill[{rcv[1:0], 3'b000} +: 8] <= MC_data_in;
              rcv <= rcv + 3'd1;
              if (rcv == 3'd3) begin
                instE_out <= 1'b1;
                inst_out  <= fill_word;
                state     <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: table rows, abort sequence and random requests
// checked against a line-ownership model and a byte memory function.
module tb_icache_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        IF_req_in;
  logic [17:0] IF_addr_in;
  logic        instE_out;
  logic [31:0] inst_out;
  logic        MC_req_out;
  logic [17:0] MC_addr_out;
  logic        MC_grant_in;
  logic [7:0]  MC_data_in;

  int checks   = 0;
  int failures = 0;

`ifdef ICACHE_EN
  localparam bit CACHED = 1'b1;
`else
  localparam bit CACHED = 1'b0;
`endif
  localparam int HL = CACHED ? 1 : 6;

  // index -> word address currently owning that line
  int line_of [int];

  typedef struct {
    logic [17:0] addr;
    int          sk;
    int          ss;
    int          sl;
    int          lat;
    logic [31:0] inst;
    bit          gap;
  } vec_t;

  vec_t v [8];

  always #5 clk_in = ~clk_in;

  icache_responder #(.INDEX_BITS(7)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .IF_req_in   (IF_req_in),
    .IF_addr_in  (IF_addr_in),
    .instE_out   (instE_out),
    .inst_out    (inst_out),
    .MC_req_out  (MC_req_out),
    .MC_addr_out (MC_addr_out),
    .MC_grant_in (MC_grant_in),
    .MC_data_in  (MC_data_in)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [17:0] a);
    case (a)
      18'h00010: return 8'h13;
      18'h00011: return 8'h05;
      18'h00012: return 8'h00;
      18'h00013: return 8'h00;
      default:   return (a[7:0] * 8'd29) ^ a[15:8] ^ 8'h6B;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [17:0] a);
    logic [17:0] b;
    b = {a[17:2], 2'b00};
    return {mem_byte(b + 18'd3), mem_byte(b + 18'd2),
            mem_byte(b + 18'd1), mem_byte(b)};
  endfunction

  // One clock: arbiter decision, edge, then the granted byte appears.
  task automatic cycle(input bit rdy, input bit en,
                       output bit g, output logic [17:0] a);
    rdy_in      = rdy;
    MC_grant_in = rdy && MC_req_out && en;
    g = MC_grant_in;
    a = MC_addr_out;
    @(posedge clk_in);
    #1;
    if (g) MC_data_in = mem_byte(a);
  endtask

  // sk: 0 none, 1 rdy low, 2 grant low; window [ss, ss+sl) in cycles.
  task automatic run_req(input logic [17:0] addr, input int sk,
                         input int ss, input int sl, input bit rnd,
                         input int want_lat, input logic [31:0] want_inst,
                         input bit gap);
    int c, exp_c, ngr, w, idx;
    bit hit, armed, g, en, rdy, req_b, ie_b, done;
    logic [17:0] a, base;
    logic [17:0] gq [$];
    w     = int'(addr[17:2]);
    idx   = w % 128;
    hit   = CACHED && line_of.exists(idx) && (line_of[idx] == w);
    base  = {addr[17:2], 2'b00};
    IF_req_in  = 1'b1;
    IF_addr_in = addr;
    c = 0; exp_c = 0; ngr = 0; armed = 0; done = 0;
    while (!done && c < 300) begin
      rdy = !(sk == 1 && c >= ss && c < ss + sl);
      en  = !(sk == 2 && c >= ss && c < ss + sl) &&
            (!rnd || $urandom_range(0, 3) != 0);
      req_b = MC_req_out;
      ie_b  = instE_out;
      cycle(rdy, en, g, a);
      c++;
      if (!rdy) begin
        chk("frz_addr", 32'(MC_addr_out), 32'(a));
        chk("frz_req", 32'(MC_req_out), 32'(req_b));
        chk("frz_inste", 32'(instE_out), 32'(ie_b));
      end else if (!g && req_b) begin
        chk("hold_addr", 32'(MC_addr_out), 32'(a));
      end
      if (exp_c == 0 && rdy && (hit || armed)) exp_c = c;
      if (g) begin
        ngr++;
        gq.push_back(a);
        if (ngr == 4) armed = 1;
      end
      done = rdy && instE_out;
    end
    if (!done) begin
      chk("timeout", 32'(c), 32'(0));
    end else begin
      chk("latency", 32'(c), 32'(exp_c));
      if (want_lat != 0) chk("lat_fixed", 32'(c), 32'(want_lat));
      chk("inst", inst_out, word_at(addr));
      if (want_inst != 0) chk("inst_fixed", inst_out, want_inst);
      chk("grants", 32'(gq.size()), hit ? 32'd0 : 32'd4);
      if (!hit) begin
        for (int i = 0; i < 4 && i < gq.size(); i++)
          chk("mc_addr", 32'(gq[i]), 32'(base + 18'(i)));
      end
      if (CACHED) line_of[idx] = w;
    end
    if (gap) begin
      IF_req_in = 1'b0;
      cycle(1'b1, 1'b1, g, a);
      chk("pulse", 32'(instE_out), 32'(0));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    logic [17:0] a;
    v[0] = '{18'h00010, 0, 0, 0, 6,  32'h00000513, 1'b0};
    v[1] = '{18'h00010, 0, 0, 0, HL, 32'h00000513, 1'b1};
    v[2] = '{18'h00030, 2, 3, 2, 8,  32'h0, 1'b1};
    v[3] = '{18'h00040, 1, 3, 3, 9,  32'h0, 1'b1};
    v[4] = '{18'h00004, 0, 0, 0, 6,  32'h0, 1'b1};
    v[5] = '{18'h00204, 0, 0, 0, 6,  32'h0, 1'b1};
    v[6] = '{18'h00004, 0, 0, 0, 6,  32'h0, 1'b1};
    v[7] = '{18'h00006, 0, 0, 0, HL, 32'h0, 1'b1};

    rst_in = 1'b1; rdy_in = 1'b1; IF_req_in = 1'b0;
    IF_addr_in = '0; MC_grant_in = 1'b0; MC_data_in = '0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    chk("rst_inste", 32'(instE_out), 32'(0));
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_mcreq", 32'(MC_req_out), 32'(0));
    chk("rst_mcaddr", 32'(MC_addr_out), 32'(0));

    for (int i = 0; i < 8; i++)
      run_req(v[i].addr, v[i].sk, v[i].ss, v[i].sl, 1'b0,
              v[i].lat, v[i].inst, v[i].gap);

    IF_req_in  = 1'b1;
    IF_addr_in = 18'h00100;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, g, a);
    IF_addr_in = 18'h00200;
    cycle(1'b1, 1'b1, g, a);
    chk("abort_req", 32'(MC_req_out), 32'(0));
    chk("abort_inste", 32'(instE_out), 32'(0));
    run_req(18'h00200, 0, 0, 0, 1'b0, 6, 32'h0, 1'b1);
    run_req(18'h00100, 0, 0, 0, 1'b0, 6, 32'h0, 1'b1);

    for (int n = 0; n < 80; n++) begin
      logic [17:0] ra;
      int sk;
      ra = 18'(($urandom_range(0, 15) + 128 * $urandom_range(0, 1) +
               4096 * $urandom_range(0, 1)) * 4 + $urandom_range(0, 3));
      sk = ($urandom_range(0, 3) == 0) ? 1 : 0;
      run_req(ra, sk, int'($urandom_range(0, 6)), int'($urandom_range(1, 4)),
              1'b1, 0, 32'h0, 1'($urandom_range(0, 1)));
    end

    IF_req_in = 1'b0;
    MC_grant_in = 1'b0;
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    line_of.delete();
    run_req(18'h00006, 0, 0, 0, 1'b0, 6, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
# icache_responder

Instruction-cache responder serving the IF stage's fetch request port. It accepts an 18-bit word-fetch request, answers hits from a direct-mapped one-word-per-line array in one cycle, and on a miss fetches the word as four bytes through the memory controller. It delivers the assembled instruction as a one-cycle valid pulse and fills the line. It sits between IF and the memory-controller arbiter. MEM has bus priority through the arbiter's grant.

## Interface
- INDEX_BITS, 7, line index width (2^INDEX_BITS lines); tag width = 16 - INDEX_BITS
- clk_in  input  1  clock; everything updates on posedge
- rst_in  input  1  synchronous, active-high reset
- rdy_in  input  1  global enable; when low, all state and outputs hold
- IF_req_in  input  1  fetch request from IF, held high every cycle until served
- IF_addr_in  input  18  fetch byte address; bits [1:0] ignored
- instE_out  output  1  instruction valid pulse to IF
- inst_out  output  32  fetched instruction, little-endian
- MC_req_out  output  1  byte-read request to the arbiter
- MC_addr_out  output  18  byte address of the current request
- MC_grant_in  input  1  arbiter accepted MC_addr_out at this edge
- MC_data_in  input  8  read byte, valid at the edge after its grant

## Operation
- State: valid[2^INDEX_BITS], tag array, data array (32 bit), FSM {IDLE, FILL}, latched word address, issue counter iss (3 bit), receive counter rcv (3 bit), byte-valid flag pend.
- Reset clears all valid bits, FSM=IDLE, instE_out=0, inst_out=0, MC_req_out=0, MC_addr_out=0, counters=0, pend=0.
- IDLE, IF_req_in=1, hit (valid && tag match):
  - set instE_out=1 and inst_out=data.
- IDLE, IF_req_in=1, miss:
  - latch the address (bits [1:0] forced to 00).
  - go to FILL with iss=rcv=0, MC_req_out=1, MC_addr_out=base.
  - instE_out=0.
- IDLE, IF_req_in=0: instE_out=0.
- FILL, issue side, each edge with MC_grant_in=1 while iss<4:
  - pend=1 for the next edge.
  - iss++.
  - MC_addr_out=base+iss+1.
  - MC_req_out drops after the grant with iss=3.
- FILL, receive side, each edge with pend=1:
  - MC_data_in goes into byte lane rcv (bits [8*rcv+7:8*rcv]).
  - rcv++.
  - pend is reloaded from that edge's grant.
- FILL completion, on the edge that captures byte 3:
  - write data, tag and valid=1 for the line.
  - instE_out=1, inst_out=assembled word.
  - FSM=IDLE.
- Grant low: iss and MC_addr_out hold. The request stays asserted.
- Abort, in FILL at any edge where IF_req_in=0 or IF_addr_in[17:2] differs from the latched address:
  - FSM=IDLE, MC_req_out=0, pend=0.
  - no array write; instE_out=0.
  - an in-flight byte is discarded.
  - a new request is not evaluated until the next edge.
- instE_out is never high for two consecutive edges from the same fill. A hit in IDLE may follow immediately.

## Timing
- Hit latency: request sampled at edge k gives instE_out high after edge k; IF samples it at k+1.
- Miss with continuous grant: detect at edge k, grants at k+1..k+4, bytes captured at k+2..k+5. instE_out rises after k+5, for 5 cycles of miss penalty.
- Each cycle of grant-low stall adds one cycle.
- Array read is combinational from IF_addr_in. The write occurs on the completion edge, and a same-line request on the next edge hits.
- rdy_in=0 freezes everything, including pend. The arbiter must not grant while rdy_in=0.

## Configuration
- ICACHE_EN defined: behaviour as above.
- ICACHE_EN undefined:
  - tag, data and valid arrays are removed.
  - every request is treated as a miss: same FILL sequence, no line write.
  - the interface is unchanged.

## Test plan
- Reset, then request 0x00010 with bytes 13,05,00,00 and continuous grant -> MC_addr_out 0x00010..0x00013; instE_out=1, inst_out=0x00000513 five cycles after request detect.
- Same address re-requested next cycle -> instE_out=1 after one edge, no MC_req_out (with ICACHE_EN); without ICACHE_EN a full refill occurs.
- Miss with grant low two cycles between bytes 1 and 2 -> MC_addr_out holds 0x00012, completion delayed exactly 2 cycles, word correct.
- Abort: miss at 0x00100, IF_addr_in switches to 0x00200 after byte 1 -> no write to line for 0x00100; new fill starts at 0x00200; a later 0x00100 request misses.
- Conflict: fill 0x00004 then 0x00204 (same index, INDEX_BITS=7) -> second evicts first; re-request 0x00004 misses.
- rdy_in low for 3 cycles mid-fill -> counters, outputs and captured bytes unchanged; completion shifts by 3 cycles.
